pcie_dllp_acknak_gen: RTL

Receive-side Data Link Layer ACK/NAK scheduler for the PCIe Gen5 DLLP block. It consumes per-TLP status events from the receive LCRC checker (sequence number and LCRC pass/fail) and tracks NEXT_RCV_SEQ. It decides accept or discard for each TLP and issues ACK (type 8'h00) and NAK (type 8'h10) DLLP requests toward the DLLP transmit framer. It is the partner of the transmit replay buffer, which consumes these ACK/NAKs.

---
 rtl/pcie_dllp_acknak_gen_pkg.sv | 21 ++
 rtl/pcie_dllp_acknak_gen_if.sv | 29 ++
 rtl/pcie_dllp_ack_timer.sv | 28 ++
 rtl/pcie_dllp_acknak_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pcie_dllp_acknak_gen_pkg.sv
// Shared types and constants for the receive-side ACK/NAK DLLP scheduler.
package pcie_dllp_acknak_gen_pkg;

    localparam int unsigned SEQ_W = 12;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef struct packed {
        logic [7:0] dllp_type;
        seq_t       seq;
    } acknak_req_t;

    // Modulo-4096 sequence distance a - b.
    function automatic seq_t seq_diff(input seq_t a, input seq_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/pcie_dllp_acknak_gen_if.sv
// TLP status events in, ACK/NAK requests out, between LCRC checker, scheduler and framer.
interface pcie_dllp_acknak_gen_if;
    import pcie_dllp_acknak_gen_pkg::*;

    logic       link_up_i;
    logic       tlp_valid_i;
    seq_t       tlp_seq_i;
    logic       tlp_lcrc_ok_i;
    logic       tlp_accept_o;
    logic       tlp_discard_o;
    logic       dllp_valid_o;
    logic       dllp_ready_i;
    logic [7:0] dllp_type_o;
    seq_t       dllp_seq_o;
    seq_t       next_rcv_seq_o;

    modport slave (
        input  link_up_i, tlp_valid_i, tlp_seq_i, tlp_lcrc_ok_i, dllp_ready_i,
        output tlp_accept_o, tlp_discard_o, dllp_valid_o, dllp_type_o, dllp_seq_o,
               next_rcv_seq_o
    );

    modport master (
        output link_up_i, tlp_valid_i, tlp_seq_i, tlp_lcrc_ok_i, dllp_ready_i,
        input  tlp_accept_o, tlp_discard_o, dllp_valid_o, dllp_type_o, dllp_seq_o,
               next_rcv_seq_o
    );

endinterface

// File: rtl/pcie_dllp_ack_timer.sv
// Saturating ACK latency counter; expires once LATENCY cycles of pending TLPs have elapsed.
module pcie_dllp_ack_timer #(
    parameter int unsigned LATENCY = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != CNT_W'(LATENCY))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire_c = (r_cnt == CNT_W'(LATENCY));

endmodule

// File: rtl/pcie_dllp_acknak_gen.sv
// Receive-side DLL scheduler: tracks NEXT_RCV_SEQ, accepts/discards TLPs and
// issues ACK/NAK DLLP requests to the transmit framer.
module pcie_dllp_acknak_gen
    import pcie_dllp_acknak_gen_pkg::*;
#(
    parameter int unsigned ACK_LATENCY  = 255,
    parameter int unsigned ACK_COALESCE = 4
) (
    input  logic                  pclk,
    input  logic                  preset,
    pcie_dllp_acknak_gen_if.slave bus
);

    localparam seq_t DUP_WINDOW = SEQ_W'(2048);

    seq_t        r_next_rcv_seq;
    seq_t        r_last_acked;
    logic        r_nak_sched;
    logic        r_nak_req;
    logic        r_dup_ack;
    logic        r_accept;
    logic        r_discard;
    logic        r_dllp_valid;
    acknak_req_t r_dllp;

    seq_t        w_dist;
    seq_t        w_pending;
    seq_t        w_ack_seq;
    logic        w_evt_accept;
    logic        w_evt_dup;
    logic        w_evt_discard;
    logic        w_new_nak;
    logic        w_ack_due;
    logic        w_load;
    logic        w_timer_clear;
    logic        w_timer_run;
    logic        w_expire_c;
    acknak_req_t w_load_req;

    // Event classification and output-register load decision.
    always_comb begin
        w_dist        = seq_diff(r_next_rcv_seq, bus.tlp_seq_i);
        w_pending     = seq_diff(r_next_rcv_seq - SEQ_W'(1), r_last_acked);
        w_ack_seq     = r_next_rcv_seq - SEQ_W'(1);
        w_evt_accept  = bus.tlp_valid_i && bus.tlp_lcrc_ok_i && (w_dist == '0);
        w_evt_dup     = bus.tlp_valid_i && bus.tlp_lcrc_ok_i && (w_dist != '0)
                        && (w_dist <= DUP_WINDOW);
        w_evt_discard = bus.tlp_valid_i && !w_evt_accept;
        w_new_nak     = w_evt_discard && !w_evt_dup && !r_nak_sched;
        w_ack_due     = (w_pending != '0)
                        && ((w_pending >= SEQ_W'(ACK_COALESCE)) || w_expire_c);
        w_load        = !r_dllp_valid && (r_nak_req || r_dup_ack || w_ack_due);
        w_load_req.dllp_type = r_nak_req ? DLLP_TYPE_NAK : DLLP_TYPE_ACK;
        w_load_req.seq       = w_ack_seq;
        w_timer_clear = !bus.link_up_i || (w_pending == '0) || w_load;
        w_timer_run   = (w_pending != '0);
    end

    pcie_dllp_ack_timer #(
        .LATENCY (ACK_LATENCY)
    ) u_ack_timer (
        .clk        (pclk),
        .rst        (preset),
        .i_clear    (w_timer_clear),
        .i_run      (w_timer_run),
        .o_expire_c (w_expire_c)
    );

    // Link-down wipes state exactly like reset, without waiting for a handshake.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_next_rcv_seq <= '0;
            r_last_acked   <= '1;
            r_nak_sched    <= 1'b0;
            r_nak_req      <= 1'b0;
            r_dup_ack      <= 1'b0;
            r_accept       <= 1'b0;
            r_discard      <= 1'b0;
            r_dllp_valid   <= 1'b0;
            r_dllp         <= '0;
        end else if (!bus.link_up_i) begin
            r_next_rcv_seq <= '0;
            r_last_acked   <= '1;
            r_nak_sched    <= 1'b0;
            r_nak_req      <= 1'b0;
            r_dup_ack      <= 1'b0;
            r_accept       <= 1'b0;
            r_discard      <= 1'b0;
            r_dllp_valid   <= 1'b0;
            r_dllp         <= '0;
        end else begin
            r_accept  <= w_evt_accept;
            r_discard <= w_evt_discard;

            if (w_evt_accept) begin
                r_next_rcv_seq <= r_next_rcv_seq + SEQ_W'(1);
            end

            if (w_evt_accept) begin
                r_nak_sched <= 1'b0;
            end else if (w_new_nak) begin
                r_nak_sched <= 1'b1;
            end

            // A fresh request outranks the clear from a concurrent load.
            if (w_new_nak) begin
                r_nak_req <= 1'b1;
            end else if (w_load) begin
                r_nak_req <= 1'b0;
            end

            if (w_evt_dup) begin
                r_dup_ack <= 1'b1;
            end else if (w_load) begin
                r_dup_ack <= 1'b0;
            end

            if (w_load) begin
                r_dllp_valid <= 1'b1;
                r_dllp       <= w_load_req;
                r_last_acked <= w_ack_seq;
            end else if (r_dllp_valid && bus.dllp_ready_i) begin
                r_dllp_valid <= 1'b0;
            end
        end
    end

    assign bus.tlp_accept_o   = r_accept;
    assign bus.tlp_discard_o  = r_discard;
    assign bus.dllp_valid_o   = r_dllp_valid;
    assign bus.dllp_type_o    = r_dllp.dllp_type;
    assign bus.dllp_seq_o     = r_dllp.seq;
    assign bus.next_rcv_seq_o = r_next_rcv_seq;

endmodule
